ahb_lite_sram_slave: RTL and testbench

- Parametrised AHB-Lite slave: word-organised SRAM model with configurable data width, depth, wait states and a read-only low region.
- Serves as the DUT/reference slave behind the AHB agent environment.
- Supports byte, halfword and word transfers, pipelined back-to-back accesses, and a two-cycle ERROR response.
- Adds programmable wait states, write protection and size/alignment checking.

---
 rtl/ahb_lite_pkg.sv | 49 ++++
 rtl/ahb_sram_bank.sv | 26 ++
 rtl/ahb_lite_sram_slave.sv | 140 ++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and byte-lane helper for the SRAM slave.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SizeByte    = 3'd0,
    SizeHalf    = 3'd1,
    SizeWord    = 3'd2,
    SizeDword   = 3'd3,
    Size16Byte  = 3'd4,
    Size32Byte  = 3'd5,
    Size64Byte  = 3'd6,
    Size128Byte = 3'd7
  } hsize_e;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr1 = 2'd2,
    StErr2 = 2'd3
  } slave_state_e;

  // Little-endian lane enables for a transfer of 2^size bytes at the given in-word offset.
  function automatic logic [7:0] byte_lane_mask(input logic [2:0] size,
                                                input logic [2:0] addr_lsbs,
                                                input int unsigned data_w);
    int unsigned off;
    int unsigned nbytes;
    logic [7:0] mask;
    nbytes = 32'd1 << size;
    off    = 32'(addr_lsbs) & (data_w / 8 - 1);
    for (int unsigned i = 0; i < 8; i++) begin
      mask[i] = (i >= off) && (i < off + nbytes) && (i < data_w / 8);
    end
    return mask;
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised storage: byte-enable synchronous write, asynchronous read, shared address.
module ahb_sram_bank #(
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [DataW/8-1:0]       be_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [DataW-1:0]         wdata_i,
  output logic [DataW-1:0]         rdata_o
);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(DataW / 8); i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: decode and checks at address phase, wait-state/error FSM, byte-lane writes.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_WORDS    = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = ADDR_W - OffW;
  localparam int unsigned AW       = $clog2(DEPTH);

  slave_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              write_q;
  hsize_e            size_q;
  logic [OffW-1:0]   off_q;
  logic [AW-1:0]     idx_q;

  logic              accept, err_any;
  logic [IdxW-1:0]   word_idx;
  logic [OffW-1:0]   align_mask;
  logic [NumBytes-1:0] be;
  logic [DATA_W-1:0] rdata;
  logic              we;
  hresp_e            resp;
  logic              unused_hburst;

  assign unused_hburst = ^HBURST;

  assign accept     = HSEL && HREADY && (htrans_e'(HTRANS) inside {TransNonseq, TransSeq});
  assign word_idx   = HADDR[ADDR_W-1:OffW];
  assign align_mask = OffW'((32'd1 << HSIZE) - 32'd1);
  assign err_any    = (32'(HSIZE) > OffW)
                   || (|(HADDR[OffW-1:0] & align_mask))
                   || (|word_idx[IdxW-1:AW])
                   || (HWRITE && (word_idx < IdxW'(RO_WORDS)));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= SizeByte;
      off_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      if (accept) begin
        write_q <= HWRITE;
        size_q  <= hsize_e'(HSIZE);
        off_q   <= HADDR[OffW-1:0];
        idx_q   <= word_idx[AW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept && err_any) begin
          state_d = StErr1;
        end else if (accept && (WAIT_STATES > 0)) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  // An OKAY data phase stays pending until the slave signals ready.
  always_comb begin
    valid_d = valid_q;
    if (accept) valid_d = !err_any;
    else if (HREADYOUT) valid_d = 1'b0;
  end

  always_comb begin
    HREADYOUT = 1'b1;
    resp      = RespOkay;
    unique case (state_q)
      StWait: HREADYOUT = 1'b0;
      StErr1: begin
        HREADYOUT = 1'b0;
        resp      = RespError;
      end
      StErr2:  resp = RespError;
      default: ;
    endcase
  end

  assign HRESP  = resp;
  assign we     = valid_q && write_q && HREADYOUT && !HRESET;
  assign be     = NumBytes'(byte_lane_mask(size_q, 3'(off_q), DATA_W));
  assign HRDATA = valid_q ? rdata : '0;

  ahb_sram_bank #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_bank (
    .clk_i   (HCLK),
    .we_i    (we),
    .be_i    (be),
    .addr_i  (idx_q),
    .wdata_i (HWDATA),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: two slaves (zero-wait with read-only low words, and three-wait) on one bus.
module tb_ahb_lite_sram_slave;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel_a = 1'b0, hsel_b = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hready, ready_a, ready_b, resp_a, resp_b, hresp, sel_dp;
  logic [31:0] rdata_a, rdata_b, hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Data-phase response mux, as in a real bus fabric.
  always_ff @(posedge clk) begin
    if (hreset) sel_dp <= 1'b0;
    else if (hready) sel_dp <= hsel_b;
  end
  assign hready = sel_dp ? ready_b : ready_a;
  assign hresp  = sel_dp ? resp_b : resp_a;
  assign hrdata = sel_dp ? rdata_b : rdata_a;

  ahb_lite_sram_slave #(
    .ADDR_W (32), .DATA_W (32), .DEPTH (1024), .WAIT_STATES (0), .RO_WORDS (4)
  ) dut_a (
    .HCLK (clk), .HRESET (hreset), .HSEL (hsel_a), .HADDR (haddr), .HTRANS (htrans),
    .HWRITE (hwrite), .HSIZE (hsize), .HBURST (hburst), .HWDATA (hwdata), .HREADY (hready),
    .HRDATA (rdata_a), .HREADYOUT (ready_a), .HRESP (resp_a)
  );

  ahb_lite_sram_slave #(
    .ADDR_W (32), .DATA_W (32), .DEPTH (1024), .WAIT_STATES (3), .RO_WORDS (0)
  ) dut_b (
    .HCLK (clk), .HRESET (hreset), .HSEL (hsel_b), .HADDR (haddr), .HTRANS (htrans),
    .HWRITE (hwrite), .HSIZE (hsize), .HBURST (hburst), .HWDATA (hwdata), .HREADY (hready),
    .HRDATA (rdata_b), .HREADYOUT (ready_b), .HRESP (resp_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer with an idle bus afterwards; call just after a rising edge with the bus ready.
  task automatic single(input logic b, input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] wd, output int lows, output logic resp0,
                        output logic resp_end, output logic [31:0] rd);
    hsel_a = !b; hsel_b = b; haddr = a; hwrite = w; hsize = s; htrans = 2'b10;
    @(posedge clk); #1;
    hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwdata = wd;
    lows = 0;
    @(negedge clk);
    resp0 = hresp;
    while (!hready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    resp_end = hresp;
    rd = hrdata;
    @(posedge clk); #1;
  endtask

  int          lows;
  logic        r0, r1;
  logic [31:0] rd;

  initial begin
    repeat (3) @(posedge clk);
    #1 hreset = 1'b0;
    @(negedge clk);
    chk("rst_ready_a", 32'(ready_a), 32'd1);
    chk("rst_resp_a", 32'(resp_a), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd1);
    @(posedge clk); #1;

    single(1'b0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, lows, r0, r1, rd);
    chk("wr_lat0", 32'(lows), 32'd0);
    chk("wr_resp", 32'(r1), 32'd0);
    single(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("rd_lat0", 32'(lows), 32'd0);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_resp", 32'(r1), 32'd0);

    single(1'b0, 32'h10, 1'b1, 3'd2, 32'h11223344, lows, r0, r1, rd);
    single(1'b0, 32'h13, 1'b1, 3'd0, 32'hAA000000, lows, r0, r1, rd);
    chk("byte_wr_resp", 32'(r1), 32'd0);
    single(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("byte_merge", rd, 32'hAA223344);

    single(1'b0, 32'h11, 1'b1, 3'd1, 32'hFFFFFFFF, lows, r0, r1, rd);
    chk("unalign_lows", 32'(lows), 32'd1);
    chk("unalign_resp1", 32'(r0), 32'd1);
    chk("unalign_resp2", 32'(r1), 32'd1);
    single(1'b0, 32'h01, 1'b0, 3'd1, 32'h0, lows, r0, r1, rd);
    chk("unalign_rd_resp", 32'(r1), 32'd1);
    chk("err_rd_zero", rd, 32'd0);
    single(1'b0, 32'h1010, 1'b1, 3'd2, 32'h0BADF00D, lows, r0, r1, rd);
    chk("range_lows", 32'(lows), 32'd1);
    chk("range_resp", 32'(r0 & r1), 32'd1);
    single(1'b0, 32'h10, 1'b0, 3'd3, 32'h0, lows, r0, r1, rd);
    chk("size_err", 32'(r0 & r1), 32'd1);
    single(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("err_no_write", rd, 32'hAA223344);

    single(1'b0, 32'h0C, 1'b1, 3'd2, 32'h12345678, lows, r0, r1, rd);
    chk("ro_err", 32'(r0 & r1), 32'd1);
    chk("ro_lows", 32'(lows), 32'd1);
    single(1'b0, 32'h10, 1'b1, 3'd2, 32'h55667788, lows, r0, r1, rd);
    chk("ro_edge_ok", 32'(r0 | r1), 32'd0);

    // Reset on the completing edge of a write must drop the write.
    hsel_a = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge clk); #1;
    hsel_a = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    @(negedge clk);
    hreset = 1'b1;
    @(posedge clk); #1 hreset = 1'b0;
    single(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("rst_abort_wr", rd, 32'h55667788);

    // Three-wait slave: pipelined write then SEQ read of the same word.
    hsel_b = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge clk); #1;
    hwrite = 1'b0; htrans = 2'b11; hwdata = 32'h0BADCAFE;
    lows = 0;
    @(negedge clk);
    while (!hready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    chk("pipe_wr_lows", 32'(lows), 32'd3);
    chk("pipe_wr_resp", 32'(hresp), 32'd0);
    @(posedge clk); #1;
    hsel_b = 1'b0; htrans = 2'b00;
    lows = 0;
    @(negedge clk);
    while (!hready && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    chk("pipe_rd_lows", 32'(lows), 32'd3);
    chk("pipe_rd_data", hrdata, 32'h0BADCAFE);
    @(posedge clk); #1;

    single(1'b1, 32'h10, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("ws3_lows", 32'(lows), 32'd3);
    chk("ws3_data", rd, 32'h0BADCAFE);
    chk("ws3_resp", 32'(r0 | r1), 32'd0);
    single(1'b1, 32'h02, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("ws3_err_lows", 32'(lows), 32'd1);
    chk("ws3_err_resp", 32'(r0 & r1), 32'd1);

    // Reset while a write sits in a wait state.
    hsel_b = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
    @(posedge clk); #1;
    hsel_b = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF0000;
    @(negedge clk);
    chk("mid_wait_low", 32'(ready_b), 32'd0);
    hreset = 1'b1;
    @(posedge clk); #1 hreset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_b), 32'd1);
    chk("post_rst_resp", 32'(resp_b), 32'd0);
    chk("post_rst_rdata", rdata_b, 32'd0);
    chk("post_rst_state", 32'(dut_b.state_q), 32'(ahb_lite_pkg::StIdle));
    @(posedge clk); #1;
    single(1'b1, 32'h10, 1'b0, 3'd2, 32'h0, lows, r0, r1, rd);
    chk("wait_abort_wr", rd, 32'h0BADCAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
